// File: rtl/fsm_seq_emitter_pkg.sv
// Shared constants for the unlock-sequence emitter:
// detector state codes, vector/code tables, emitter state encoding.
package fsm_seq_pkg;

    localparam int NUM_STEPS = 12;

    localparam logic [16:0] S1  = 17'd0;
    localparam logic [16:0] S2  = 17'd200;
    localparam logic [16:0] S3  = 17'd700;
    localparam logic [16:0] S4  = 17'd900;
    localparam logic [16:0] S5  = 17'd1300;
    localparam logic [16:0] S6  = 17'd1800;
    localparam logic [16:0] S7  = 17'd2300;
    localparam logic [16:0] S8  = 17'd2800;
    localparam logic [16:0] S9  = 17'd3100;
    localparam logic [16:0] S10 = 17'd3400;
    localparam logic [16:0] S11 = 17'd3600;
    localparam logic [16:0] S12 = 17'd3800;
    localparam logic [16:0] S13 = 17'd4100;

    // {i1,i2,i3,i4} per step
    localparam logic [3:0] VEC [NUM_STEPS] = '{
        4'b0010, 4'b1001, 4'b0000, 4'b0010,
        4'b0100, 4'b1000, 4'b0001, 4'b0000,
        4'b0001, 4'b0010, 4'b1000, 4'b0000
    };

    // detector code once each step's vector is consumed
    localparam logic [16:0] CODE [NUM_STEPS] = '{
        S2, S3, S4, S5, S6, S7,
        S8, S9, S10, S11, S12, S13
    };

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/fsm_seq_emitter_if.sv
// Request/response bundle between a sequence requester
// and the emitter that drives the detector lines.
interface fsm_seq_emitter_if;

    logic        start;
    logic        abort;
    logic        err_en;
    logic [3:0]  err_step;
    logic        o_i1;
    logic        o_i2;
    logic        o_i3;
    logic        o_i4;
    logic        busy;
    logic [3:0]  step_idx;
    logic [16:0] exp_code;
    logic        done;

    modport master (
        output start, abort, err_en, err_step,
        input  o_i1, o_i2, o_i3, o_i4,
        input  busy, step_idx, exp_code, done
    );

    modport slave (
        input  start, abort, err_en, err_step,
        output o_i1, o_i2, o_i3, o_i4,
        output busy, step_idx, exp_code, done
    );

endinterface

// File: rtl/fsm_seq_emitter_rom.sv
// Step index to {vector, expected code} lookup.
// Out-of-range steps return zeros.
module fsm_seq_rom (
    input  logic [3:0]  i_step,
    output logic [3:0]  o_vec,
    output logic [16:0] o_code
);
    import fsm_seq_pkg::*;

    // table lookup guarded against indices 12..15
    always_comb begin
        o_vec  = '0;
        o_code = '0;
        if (i_step < 4'(NUM_STEPS)) begin
            o_vec  = VEC[i_step];
            o_code = CODE[i_step];
        end
    end

endmodule

// File: rtl/fsm_seq_emitter.sv
// Drives the 12-vector unlock sequence onto the detector lines,
// with per-step hold, abort and single-step fault injection.
module fsm_seq_emitter #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    fsm_seq_emitter_if.slave bus
);
    import fsm_seq_pkg::*;

    localparam logic [7:0] HOLD_TC = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] LAST    = 4'(NUM_STEPS - 1);

    logic [1:0]  r_state, w_nstate;
    logic [3:0]  r_step, w_nstep;
    logic [7:0]  r_hold, w_nhold;
    logic        r_err_en, w_nerr_en;
    logic [3:0]  r_err_step, w_nerr_step;
    logic [3:0]  r_vec;
    logic [16:0] r_code;
    logic        r_busy;
    logic        r_done;
    logic        w_tc;
    logic        w_fault;
    logic [3:0]  w_rom_vec;
    logic [16:0] w_rom_code;

    // lookup is done on the next step so outputs stay aligned to step_idx
    fsm_seq_rom u_rom (
        .i_step (w_nstep),
        .o_vec  (w_rom_vec),
        .o_code (w_rom_code)
    );

    assign w_tc    = (r_hold == HOLD_TC);
    assign w_fault = w_nerr_en && (w_nerr_step == w_nstep);

    // next-state, step, hold counter and fault latch
    always_comb begin
        w_nstate    = r_state;
        w_nstep     = r_step;
        w_nhold     = r_hold;
        w_nerr_en   = r_err_en;
        w_nerr_step = r_err_step;
        unique case (1'b1)
            (r_state == ST_IDLE): begin
                if (!bus.abort && bus.start) begin
                    w_nstate    = ST_DRIVE;
                    w_nstep     = '0;
                    w_nhold     = '0;
                    w_nerr_en   = bus.err_en;
                    w_nerr_step = bus.err_step;
                end
            end
            (r_state == ST_DRIVE): begin
                if (bus.abort) begin
                    w_nstate = ST_IDLE;
                    w_nstep  = '0;
                    w_nhold  = '0;
                end else if (w_tc) begin
                    w_nhold = '0;
                    if (r_step == LAST) begin
                        w_nstate = ST_DONE;
                        w_nstep  = '0;
                    end else begin
                        w_nstep = r_step + 4'd1;
                    end
                end else begin
                    w_nhold = r_hold + 8'd1;
                end
            end
            default: begin
                w_nstate = ST_IDLE;
                w_nstep  = '0;
                w_nhold  = '0;
            end
        endcase
    end

    // state registers and registered detector-facing outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_hold     <= '0;
            r_err_en   <= 1'b0;
            r_err_step <= '0;
            r_vec      <= '0;
            r_code     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nstate;
            r_step     <= w_nstep;
            r_hold     <= w_nhold;
            r_err_en   <= w_nerr_en;
            r_err_step <= w_nerr_step;
            r_busy     <= (w_nstate == ST_DRIVE);
            r_done     <= (w_nstate == ST_DONE);
            if (w_nstate == ST_DRIVE) begin
                r_vec  <= w_fault ? (w_rom_vec ^ 4'b1111) : w_rom_vec;
                r_code <= w_fault ? '0 : w_rom_code;
            end else begin
                r_vec  <= '0;
                r_code <= '0;
            end
        end
    end

    assign {bus.o_i1, bus.o_i2, bus.o_i3, bus.o_i4} = r_vec;
    assign bus.busy     = r_busy;
    assign bus.step_idx = r_step;
    assign bus.exp_code = r_code;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_fsm_seq_emitter.sv
// Bench for fsm_seq_emitter: two instances (hold 1 and 3)
// checked cycle by cycle against a timeline model.
module tb_fsm_seq_emitter;

    logic clk;
    logic reset;

    int tests;
    int fails;

    int vec_m [12]  = '{2, 9, 0, 2, 4, 8, 1, 0, 1, 2, 8, 0};
    int code_m [12] = '{200, 700, 900, 1300, 1800, 2300,
                        2800, 3100, 3400, 3600, 3800, 4100};

    fsm_seq_emitter_if b1();
    fsm_seq_emitter_if b3();

    fsm_seq_emitter #(.HOLD_CYCLES(1)) u_h1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    fsm_seq_emitter #(.HOLD_CYCLES(3)) u_h3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [26:0] obs(input int w);
        if (w == 1)
            return {b1.busy, b1.step_idx, b1.exp_code,
                    b1.o_i1, b1.o_i2, b1.o_i3, b1.o_i4, b1.done};
        else
            return {b3.busy, b3.step_idx, b3.exp_code,
                    b3.o_i1, b3.o_i2, b3.o_i3, b3.o_i4, b3.done};
    endfunction

    function automatic logic [26:0] mk(input bit b, input int st,
                                       input int code, input int v,
                                       input bit d);
        return {b, 4'(st), 17'(code), 4'(v), d};
    endfunction

    task automatic drv(input int w, input bit s, input bit a,
                       input bit e, input logic [3:0] es);
        if (w == 1) begin
            b1.start = s; b1.abort = a; b1.err_en = e; b1.err_step = es;
        end else begin
            b3.start = s; b3.abort = a; b3.err_en = e; b3.err_step = es;
        end
    endtask

    task automatic chk(input string tag, input int w, input logic [26:0] e);
        logic [26:0] o;
        o = obs(w);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One start; model: cycle n after acceptance is step n/h,
    // done at n==12h, idle afterwards. Optional abort and stray start.
    task automatic run(input int w, input int h, input bit ee,
                       input int es, input int ab_step, input int noise_n);
        logic [26:0] e;
        int st;
        bit f;
        drv(w, 1, 0, ee, 4'(es));
        @(posedge clk);
        #1 drv(w, 0, 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        for (int n = 0; n <= 12 * h + 1; n++) begin
            @(negedge clk);
            if (n < 12 * h) begin
                st = n / h;
                f  = ee && (es == st);
                e  = mk(1, st, f ? 0 : code_m[st],
                        f ? (vec_m[st] ^ 15) : vec_m[st], 0);
            end else if (n == 12 * h) begin
                e = mk(0, 0, 0, 0, 1);
            end else begin
                e = mk(0, 0, 0, 0, 0);
            end
            chk($sformatf("seq_h%0d_n%0d", h, n), w, e);
            if (ab_step >= 0 && n == ab_step * h) begin
                drv(w, 0, 1, 0, 4'd0);
                @(posedge clk);
                #1 drv(w, 0, 0, 0, 4'd0);
                @(negedge clk);
                chk($sformatf("abort_h%0d_s%0d", h, ab_step), w, mk(0, 0, 0, 0, 0));
                return;
            end
            if (n == noise_n || n == 12 * h) begin
                drv(w, 1, 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)));
                @(posedge clk);
                #1 drv(w, 0, 0, 0, 4'd0);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        drv(1, 0, 0, 0, 4'd0);
        drv(3, 0, 0, 0, 4'd0);

        // reset held low with start asserted
        reset = 1'b0;
        drv(1, 1, 0, 0, 4'd0);
        drv(3, 1, 0, 0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_h1_%0d", i), 1, mk(0, 0, 0, 0, 0));
            chk($sformatf("rst_h3_%0d", i), 3, mk(0, 0, 0, 0, 0));
        end
        drv(1, 0, 0, 0, 4'd0);
        drv(3, 0, 0, 0, 4'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_h1", 1, mk(0, 0, 0, 0, 0));
        chk("idle_h3", 3, mk(0, 0, 0, 0, 0));

        // clean runs, both hold settings, stray start mid-run
        run(1, 1, 0, 0, -1, $urandom_range(1, 10));
        run(3, 3, 0, 0, -1, $urandom_range(1, 34));

        // fault at step 4, then random fault step, then out-of-range
        run(1, 1, 1, 4, -1, -1);
        run(3, 3, 1, 4, -1, -1);
        run(1, 1, 1, $urandom_range(0, 11), -1, -1);
        run(3, 3, 1, $urandom_range(12, 15), -1, -1);
        run(1, 1, 1, 11, -1, -1);

        // abort at step 6, replay, random abort
        run(1, 1, 0, 0, 6, -1);
        run(1, 1, 0, 0, -1, -1);
        run(3, 3, 0, 0, 6, -1);
        run(3, 3, 1, $urandom_range(0, 11), $urandom_range(0, 11), -1);
        run(1, 1, 0, 0, 11, -1);

        // start with abort in idle is dropped
        drv(1, 1, 1, 1, 4'd2);
        drv(3, 1, 1, 1, 4'd2);
        @(posedge clk);
        #1 drv(1, 0, 0, 0, 4'd0);
        drv(3, 0, 0, 0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("stab_h1_%0d", i), 1, mk(0, 0, 0, 0, 0));
            chk($sformatf("stab_h3_%0d", i), 3, mk(0, 0, 0, 0, 0));
        end

        // async reset mid-sequence clears outputs without a clock edge
        drv(3, 1, 0, 0, 4'd0);
        @(posedge clk);
        #1 drv(3, 0, 0, 0, 4'd0);
        repeat (7) @(posedge clk);
        #3 chk("pre_arst", 3, mk(1, 2, 900, 0, 0));
        reset = 1'b0;
        #1 chk("arst_h3", 3, mk(0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_arst", 3, mk(0, 0, 0, 0, 0));

        // sequence replays cleanly after reset
        run(3, 3, 0, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
